bn_stats_controller: RTL and testbench

BN_STATS_CONTROLLER -- requirements
Module: bn_stats_controller

---
 rtl/bn_pkg.sv | 20 ++
 rtl/bn_stats_table.sv | 48 ++++
 rtl/bn_stats_controller.sv | 175 +++++++++++++++++
 tb/tb_bn_stats_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// Shared types and constants for the batch-norm statistics controller.
package bn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_HOLD,
    ST_DRAIN,
    ST_READY,
    ST_ERROR
  } bn_state_t;

  // Extra DRAIN cycles beyond CHANNELS before a missing acc_done is an error.
  localparam int TIMEOUT_MARGIN = 8;

  function automatic logic is_busy_state(input bn_state_t s);
    return (s == ST_FEED) || (s == ST_HOLD) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/bn_stats_table.sv
// Per-channel {sum, sum_sq} register file: one write port, one registered read port.
module bn_stats_table #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_sum,
  input  logic [WIDTH-1:0] wr_sum_sq,
  input  logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] rd_sum,
  output logic [WIDTH-1:0] rd_sum_sq
);

  // Padded to the full 5-bit address space so unused channels read back as zero.
  logic [31:0][2*WIDTH-1:0] entry_flat;
  logic [2*WIDTH-1:0]       rd_data_reg;

  for (genvar gi = 0; gi < 32; gi++) begin : g_entry
    if (gi < CHANNELS) begin : g_live
      logic [2*WIDTH-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_reg <= '0;
        end else if (we && (wr_addr == 5'(gi))) begin
          entry_reg <= {wr_sum, wr_sum_sq};
        end
      end
      assign entry_flat[gi] = entry_reg;
    end else begin : g_pad
      assign entry_flat[gi] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= entry_flat[rd_addr];
    end
  end

  assign rd_sum    = rd_data_reg[2*WIDTH-1:WIDTH];
  assign rd_sum_sq = rd_data_reg[WIDTH-1:0];

endmodule

// File: rtl/bn_stats_controller.sv
// Feeds one channel-major batch into an accumulator and captures per-channel results.
// Define BN_CTRL_TIMEOUT_EN to bound the wait for acc_done in DRAIN.
module bn_stats_controller
  import bn_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BATCH_SIZE = 10,
  parameter int CHANNELS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             stats_valid,
  output logic             err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [4:0]       s_channel,
  output logic             acc_en,
  output logic             acc_valid,
  output logic [WIDTH-1:0] acc_x,
  output logic [4:0]       acc_channel,
  input  logic [WIDTH-1:0] acc_sum,
  input  logic [WIDTH-1:0] acc_sum_sq,
  input  logic [4:0]       acc_channel_out,
  input  logic             acc_valid_out,
  input  logic             acc_done,
  input  logic [4:0]       rd_channel,
  output logic [WIDTH-1:0] rd_sum,
  output logic [WIDTH-1:0] rd_sum_sq
);

  bn_state_t        state_reg, state_next;
  logic [7:0]       round_reg;
  logic [4:0]       chan_reg;
  logic [WIDTH-1:0] hold_x_reg;
  logic             held_pending_reg;
  logic             busy_reg, stats_valid_reg, err_reg, s_ready_reg, acc_en_reg;
  logic             acc_valid_reg;
  logic [WIDTH-1:0] acc_x_reg;
  logic [4:0]       acc_channel_reg;

  logic xfer, chan_ok, last_chan, last_round, capture, feed_entry, tbl_we, to_expired;

  assign xfer       = s_valid && s_ready_reg;
  assign chan_ok    = (s_channel == chan_reg);
  assign last_chan  = (chan_reg == 5'(CHANNELS - 1));
  assign last_round = (round_reg == 8'(BATCH_SIZE - 1));
  assign capture    = (state_reg == ST_FEED) && last_round && (chan_reg == 5'd0);
  assign feed_entry = (state_next == ST_FEED) && (state_reg != ST_FEED);

`ifdef BN_CTRL_TIMEOUT_EN
  localparam int TO_LIMIT = CHANNELS + TIMEOUT_MARGIN;
  logic [5:0] to_cnt_reg;

  assign to_expired = (to_cnt_reg == 6'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_reg <= '0;
    end else if (state_reg != ST_DRAIN) begin
      to_cnt_reg <= '0;
    end else if (!to_expired) begin
      to_cnt_reg <= to_cnt_reg + 6'd1;
    end
  end
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start) state_next = ST_FEED;
      ST_FEED: begin
        if (xfer && !chan_ok)      state_next = ST_ERROR;
        else if (xfer && capture)  state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (xfer && !chan_ok)        state_next = ST_ERROR;
        else if (xfer && last_chan)  state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (acc_done)        state_next = ST_READY;
        else if (to_expired) state_next = ST_ERROR;
      end
      ST_READY: if (start) state_next = ST_FEED;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      round_reg        <= '0;
      chan_reg         <= '0;
      hold_x_reg       <= '0;
      held_pending_reg <= 1'b0;
      busy_reg         <= 1'b0;
      stats_valid_reg  <= 1'b0;
      err_reg          <= 1'b0;
      s_ready_reg      <= 1'b0;
      acc_en_reg       <= 1'b0;
      acc_valid_reg    <= 1'b0;
      acc_x_reg        <= '0;
      acc_channel_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      busy_reg        <= is_busy_state(state_next);
      stats_valid_reg <= (state_next == ST_READY);
      err_reg         <= (state_next == ST_ERROR);
      s_ready_reg     <= (state_next == ST_FEED) || (state_next == ST_HOLD);
      acc_en_reg      <= !((state_next == ST_IDLE) || (state_next == ST_ERROR));
      acc_valid_reg   <= 1'b0;

      if (feed_entry) begin
        round_reg        <= '0;
        chan_reg         <= '0;
        held_pending_reg <= 1'b0;
      end else if (xfer && chan_ok) begin
        if (last_chan) begin
          chan_reg  <= '0;
          round_reg <= round_reg + 8'd1;
        end else begin
          chan_reg <= chan_reg + 5'd1;
        end
        // Last-round channel 0 is parked and issued after the rest of the round.
        if (capture) begin
          hold_x_reg <= s_data;
        end else begin
          acc_valid_reg   <= 1'b1;
          acc_x_reg       <= s_data;
          acc_channel_reg <= s_channel;
        end
        if ((state_reg == ST_HOLD) && last_chan) held_pending_reg <= 1'b1;
      end else if ((state_reg == ST_DRAIN) && held_pending_reg && !acc_valid_reg) begin
        // Waiting one idle cycle keeps issues non-adjacent.
        acc_valid_reg    <= 1'b1;
        acc_x_reg        <= hold_x_reg;
        acc_channel_reg  <= 5'd0;
        held_pending_reg <= 1'b0;
      end
    end
  end

  assign tbl_we = (state_reg == ST_DRAIN) && acc_valid_out &&
                  ({1'b0, acc_channel_out} < 6'(CHANNELS));

  bn_stats_table #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .we        (tbl_we),
    .wr_addr   (acc_channel_out),
    .wr_sum    (acc_sum),
    .wr_sum_sq (acc_sum_sq),
    .rd_addr   (rd_channel),
    .rd_sum    (rd_sum),
    .rd_sum_sq (rd_sum_sq)
  );

  assign busy        = busy_reg;
  assign stats_valid = stats_valid_reg;
  assign err         = err_reg;
  assign s_ready     = s_ready_reg;
  assign acc_en      = acc_en_reg;
  assign acc_valid   = acc_valid_reg;
  assign acc_x       = acc_x_reg;
  assign acc_channel = acc_channel_reg;

endmodule

// File: tb/tb_bn_stats_controller.sv
// Randomized bench for bn_stats_controller with a behavioural accumulator and stats model.
module tb_bn_stats_controller;
  localparam int W = 16;
  localparam int B = 3;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         busy, stats_valid, err;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic [4:0]   s_channel = '0;
  logic         acc_en, acc_valid;
  logic [W-1:0] acc_x;
  logic [4:0]   acc_channel;
  logic [W-1:0] acc_sum = '0;
  logic [W-1:0] acc_sum_sq = '0;
  logic [4:0]   acc_channel_out = '0;
  logic         acc_valid_out = 1'b0;
  logic         acc_done = 1'b0;
  logic [4:0]   rd_channel = '0;
  logic [W-1:0] rd_sum, rd_sum_sq;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_sum [C];
  logic [W-1:0] model_sq  [C];
  logic [W-1:0] iss_x  [$];
  logic [4:0]   iss_ch [$];
  int           consec = 0;
  bit           prev_v = 1'b0;

  always #5 clk = ~clk;

  bn_stats_controller #(.WIDTH(W), .BATCH_SIZE(B), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .stats_valid(stats_valid), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_channel(s_channel),
    .acc_en(acc_en), .acc_valid(acc_valid), .acc_x(acc_x), .acc_channel(acc_channel),
    .acc_sum(acc_sum), .acc_sum_sq(acc_sum_sq), .acc_channel_out(acc_channel_out),
    .acc_valid_out(acc_valid_out), .acc_done(acc_done),
    .rd_channel(rd_channel), .rd_sum(rd_sum), .rd_sum_sq(rd_sum_sq)
  );

  // Accumulator-side view of every issued sample.
  always @(negedge clk) begin
    if (acc_valid) begin
      iss_ch.push_back(acc_channel);
      iss_x.push_back(acc_x);
      if (prev_v) consec++;
    end
    prev_v = acc_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [4:0] ch, input bit toggle);
    bit done;
    done = 1'b0;
    s_valid = 1'b1; s_data = d; s_channel = ch;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk); #1;
    end
    check_eq("send_accepted", 32'(done), 32'd1);
    s_valid = 1'b0;
    if (toggle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rd(input logic [4:0] ch, output logic [W-1:0] s, output logic [W-1:0] q);
    rd_channel = ch;
    @(posedge clk); #1;
    s = rd_sum; q = rd_sum_sq;
  endtask

  task automatic run_batch(input bit rnd, input bit toggle, input bit start_mid, input bit no_done);
    logic [W-1:0] data [B][C];
    logic [W-1:0] exp_x [$];
    logic [4:0]   exp_ch [$];
    logic [W-1:0] es [C];
    logic [W-1:0] eq [C];
    logic [W-1:0] as_ [C];
    logic [W-1:0] aq [C];
    logic [W-1:0] s, q;
    int           wait_cnt, c;
    iss_x.delete(); iss_ch.delete(); consec = 0;
    for (int i = 0; i < C; i++) begin es[i] = '0; eq[i] = '0; as_[i] = '0; aq[i] = '0; end
    for (int r = 0; r < B; r++)
      for (int j = 0; j < C; j++) begin
        data[r][j] = rnd ? W'($urandom) : W'(j + 1);
        es[j] = es[j] + data[r][j];
        eq[j] = eq[j] + W'(32'(data[r][j]) * 32'(data[r][j]));
      end
    // Order the accumulator must see: full rounds, then last round 1..C-1, then channel 0.
    for (int r = 0; r < B - 1; r++)
      for (int j = 0; j < C; j++) begin exp_ch.push_back(5'(j)); exp_x.push_back(data[r][j]); end
    for (int j = 1; j < C; j++) begin exp_ch.push_back(5'(j)); exp_x.push_back(data[B-1][j]); end
    exp_ch.push_back(5'd0); exp_x.push_back(data[B-1][0]);

    pulse_start();
    check_eq("feed_busy", 32'(busy), 32'd1);
    check_eq("feed_stats_valid", 32'(stats_valid), 32'd0);
    rd(5'd1, s, q);
    check_eq("persist_sum", 32'(s), 32'(model_sum[1]));
    check_eq("persist_sq", 32'(q), 32'(model_sq[1]));

    for (int r = 0; r < B; r++)
      for (int j = 0; j < C; j++) begin
        send(data[r][j], 5'(j), toggle);
        if (start_mid && r == 1 && j == 1) begin
          pulse_start();
          check_eq("start_mid_busy", 32'(busy), 32'd1);
        end
      end

    if (no_done) begin
`ifdef BN_CTRL_TIMEOUT_EN
      repeat (C + 7) @(posedge clk);
      #1;
      check_eq("timeout_early_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      check_eq("timeout_err", 32'(err), 32'd1);
      check_eq("timeout_busy", 32'(busy), 32'd0);
      return;
`else
      repeat (40) @(posedge clk);
      #1;
      check_eq("drain_wait_err", 32'(err), 32'd0);
      check_eq("drain_wait_busy", 32'(busy), 32'd1);
`endif
    end

    wait_cnt = 0;
    while (iss_ch.size() < B * C && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("issue_count", 32'(iss_ch.size()), 32'(B * C));
    for (int i = 0; i < B * C && i < iss_ch.size(); i++) begin
      check_eq($sformatf("issue_ch[%0d]", i), 32'(iss_ch[i]), 32'(exp_ch[i]));
      check_eq($sformatf("issue_x[%0d]", i), 32'(iss_x[i]), 32'(exp_x[i]));
    end
    if (toggle) check_eq("no_back_to_back", 32'(consec), 32'd0);
    check_eq("drain_busy", 32'(busy), 32'd1);
    check_eq("drain_s_ready", 32'(s_ready), 32'd0);
    check_eq("drain_stats_valid", 32'(stats_valid), 32'd0);
    check_eq("drain_acc_en", 32'(acc_en), 32'd1);

    // Behavioural accumulator: sums whatever was issued, returns it out of order.
    for (int i = 0; i < iss_ch.size(); i++)
      if (iss_ch[i] < 5'(C)) begin
        as_[iss_ch[i]] = as_[iss_ch[i]] + iss_x[i];
        aq[iss_ch[i]]  = aq[iss_ch[i]] + W'(32'(iss_x[i]) * 32'(iss_x[i]));
      end
    for (int k = 0; k < C; k++) begin
      c = (k + 3) % C;
      acc_valid_out = 1'b1; acc_channel_out = 5'(c);
      acc_sum = as_[c]; acc_sum_sq = aq[c];
      @(posedge clk); #1;
    end
    acc_channel_out = 5'(C); acc_sum = '1; acc_sum_sq = '1;
    @(posedge clk); #1;
    acc_valid_out = 1'b0; acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    check_eq("ready_stats_valid", 32'(stats_valid), 32'd1);
    check_eq("ready_busy", 32'(busy), 32'd0);
    check_eq("ready_acc_en", 32'(acc_en), 32'd1);

    for (int i = 0; i < C; i++) begin model_sum[i] = es[i]; model_sq[i] = eq[i]; end
    for (int i = 0; i < C; i++) begin
      rd(5'(i), s, q);
      check_eq($sformatf("rd_sum[%0d]", i), 32'(s), 32'(model_sum[i]));
      check_eq($sformatf("rd_sq[%0d]", i), 32'(q), 32'(model_sq[i]));
    end
    rd(5'(C), s, q);
    check_eq("rd_oob_sum", 32'(s), 32'd0);
    rd(5'd31, s, q);
    check_eq("rd_oob31_sq", 32'(q), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s, q;
    for (int i = 0; i < C; i++) begin model_sum[i] = '0; model_sq[i] = '0; end

    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stats_valid", 32'(stats_valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_acc_en", 32'(acc_en), 32'd0);
    check_eq("rst_acc_valid", 32'(acc_valid), 32'd0);
    check_eq("rst_acc_x", 32'(acc_x), 32'd0);
    check_eq("rst_acc_channel", 32'(acc_channel), 32'd0);
    check_eq("rst_rd_sum", 32'(rd_sum), 32'd0);
    check_eq("rst_rd_sum_sq", 32'(rd_sum_sq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_acc_en", 32'(acc_en), 32'd0);

    // Value = channel + 1 batch; channel 2 gives 3+3+3 and 9+9+9.
    run_batch(1'b0, 1'b0, 1'b0, 1'b0);
    rd(5'd2, s, q);
    check_eq("ch2_sum", 32'(s), 32'd9);
    check_eq("ch2_sum_sq", 32'(q), 32'd27);

    run_batch(1'b1, 1'b0, 1'b0, 1'b0);
    run_batch(1'b0, 1'b1, 1'b0, 1'b0);
    run_batch(1'b1, 1'b1, 1'b0, 1'b0);
    run_batch(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset partway through the second round.
    pulse_start();
    for (int i = 0; i < C + 2; i++) send(W'($urandom), 5'(i % C), 1'b0);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("midrst_busy_hold", 32'(busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < C; i++) begin model_sum[i] = '0; model_sq[i] = '0; end
    @(posedge clk); #1;
    for (int i = 0; i < C; i++) begin
      rd(5'(i), s, q);
      check_eq($sformatf("midrst_cleared[%0d]", i), 32'(s), 32'd0);
    end
    check_eq("midrst_stats_valid", 32'(stats_valid), 32'd0);
    run_batch(1'b1, 1'b0, 1'b0, 1'b0);

    // DRAIN without acc_done.
    run_batch(1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < C; i++) begin model_sum[i] = '0; model_sq[i] = '0; end
    @(posedge clk); #1;

    // Out-of-order channel on the second sample.
    pulse_start();
    iss_x.delete(); iss_ch.delete();
    send(16'h1234, 5'd0, 1'b0);
    s_valid = 1'b1; s_data = 16'h5555; s_channel = 5'd3;
    @(negedge clk);
    check_eq("err_pre_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    check_eq("err_flag", 32'(err), 32'd1);
    check_eq("err_s_ready", 32'(s_ready), 32'd0);
    check_eq("err_acc_en", 32'(acc_en), 32'd0);
    check_eq("err_stats_valid", 32'(stats_valid), 32'd0);
    check_eq("err_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("err_no_issue", 32'(iss_ch.size()), 32'd1);
    pulse_start();
    @(posedge clk); #1;
    check_eq("err_sticky", 32'(err), 32'd1);
    check_eq("err_sticky_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("err_cleared", 32'(err), 32'd0);
    rd(5'd0, s, q);
    check_eq("err_table_zero", 32'(s), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
